// File: rtl/binary_divider.sv
// binary_divider
//
// Sequential restoring (shift-subtract) unsigned divider. A 2*DATA_W-bit
// dividend is divided by a DATA_W-bit divisor, giving a DATA_W-bit quotient
// and remainder. It is the inverse companion of the shift-add multiplier and
// uses the same start/Ready handshake: a small controller FSM steps a
// register datapath through one shift and one conditional subtract per
// quotient bit.
//
// Ports:
//   clock      in   1          rising-edge clock
//   reset_n    in   1          asynchronous active-low reset
//   start      in   1          request, only sampled while Ready=1
//   dividend   in   2*DATA_W   sampled on the accepting edge
//   divisor    in   DATA_W     sampled on the accepting edge
//   quotient   out  DATA_W     result, valid while Ready=1
//   remainder  out  DATA_W     result, valid while Ready=1
//   overflow   out  1          last request divided by zero or did not fit
//   Ready      out  1          idle, result valid, start accepted
//
// Optional feature macro: BINARY_DIVIDER_EARLY_EXIT_EN
//   When defined, a zero dividend with a nonzero divisor finishes on the
//   accepting edge (0 r 0) instead of running the full iteration sequence.

module binary_divider #(
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2*DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]     divisor,
  output logic [DATA_W-1:0]     quotient,
  output logic [DATA_W-1:0]     remainder,
  output logic                  overflow,
  output logic                  Ready
);

  localparam int P_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W:0]     r_reg;
  logic [DATA_W-1:0]   q_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [P_W-1:0]      p_reg;
  logic                ov_reg;
  logic                ready_reg;

  logic [DATA_W-1:0]   dividend_hi;
  logic [DATA_W-1:0]   dividend_lo;
  logic                load_overflow;
  logic                load_zero;

  // The quotient only fits in DATA_W bits when the upper dividend half is
  // strictly below the divisor; this also keeps R < 2B after every shift,
  // so the DATA_W+1-bit partial remainder never wraps.
  always_comb begin
    dividend_hi   = dividend[2*DATA_W-1:DATA_W];
    dividend_lo   = dividend[DATA_W-1:0];
    load_overflow = (divisor == '0) || (dividend_hi >= divisor);
    load_zero     = (divisor != '0) && (dividend == '0);
  end

  // Controller and datapath in one block. Ready is registered alongside the
  // state so it is exactly "state is S_IDLE" without a decode on the output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= P_W'(DATA_W);
      ov_reg    <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            b_reg  <= divisor;
            p_reg  <= P_W'(DATA_W);
            ov_reg <= load_overflow;
            if (load_overflow) begin
              // Result is reported immediately; the FSM never leaves idle.
              r_reg <= '0;
              q_reg <= '0;
            end
`ifdef BINARY_DIVIDER_EARLY_EXIT_EN
            else if (load_zero) begin
              r_reg <= '0;
              q_reg <= '0;
            end
`endif
            else begin
              r_reg     <= {1'b0, dividend_hi};
              q_reg     <= dividend_lo;
              state     <= S_SHIFT;
              ready_reg <= 1'b0;
            end
          end
        end

        S_SHIFT: begin
          // {R,Q} shifts left as one register; Q[0] is filled by S_SUB.
          r_reg <= {r_reg[DATA_W-1:0], q_reg[DATA_W-1]};
          q_reg <= {q_reg[DATA_W-2:0], 1'b0};
          p_reg <= p_reg - P_W'(1);
          state <= S_SUB;
        end

        S_SUB: begin
          if (r_reg >= {1'b0, b_reg}) begin
            r_reg    <= r_reg - {1'b0, b_reg};
            q_reg[0] <= 1'b1;
          end
          if (p_reg == '0) begin
            state     <= S_IDLE;
            ready_reg <= 1'b1;
          end else begin
            state <= S_SHIFT;
          end
        end

        default: begin
          state     <= S_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // In the default build load_zero has no consumer; keep it referenced so
  // both builds share the same signal set.
  logic unused_load_zero;
  always_comb unused_load_zero = load_zero;

  always_comb begin
    quotient  = q_reg;
    remainder = r_reg[DATA_W-1:0];
    overflow  = ov_reg;
    Ready     = ready_reg;
  end

endmodule

// File: tb/tb_binary_divider.sv
// tb_binary_divider
//
// Self-checking bench for binary_divider (DATA_W = 8). A table of directed
// vectors and a batch of random requests are checked against an arithmetic
// reference model; short hand-written sequences cover the mid-operation
// start, the asynchronous reset, back-to-back requests and result holding.

module tb_binary_divider;

  localparam int DATA_W = 8;
  localparam int TIMEOUT = 200;

`ifdef BINARY_DIVIDER_EARLY_EXIT_EN
  localparam int ZERO_CYC = 0;
`else
  localparam int ZERO_CYC = 16;
`endif

  logic                clock;
  logic                reset_n;
  logic                start;
  logic [2*DATA_W-1:0] dividend;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   quotient;
  logic [DATA_W-1:0]   remainder;
  logic                overflow;
  logic                Ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int          exp_q;
    int          exp_r;
    int          exp_ov;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  binary_divider #(.DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow),
    .Ready     (Ready)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares one value against its expectation and keeps the tallies.
  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for Ready; returns the results
  // and the number of cycles Ready stayed low after the accepting edge.
  task automatic apply_stimulus(input logic [15:0] dvd, input logic [7:0] dvs,
                                output int q, output int r, output int ov,
                                output int cyc);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom_range(0, 65535);
    divisor  = 8'($urandom_range(0, 255));
    cyc = 0;
    while (!Ready && cyc < TIMEOUT) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    q  = int'(quotient);
    r  = int'(remainder);
    ov = int'(overflow);
  endtask

  // Reference model: plain integer division with the fit rule.
  task automatic model(input logic [15:0] dvd, input logic [7:0] dvs,
                       output int q, output int r, output int ov, output int cyc);
    int quo;
    if (dvs == 0) begin
      q = 0; r = 0; ov = 1; cyc = 0;
    end else begin
      quo = int'(dvd) / int'(dvs);
      if (quo > 255) begin
        q = 0; r = 0; ov = 1; cyc = 0;
      end else begin
        q = quo;
        r = int'(dvd) % int'(dvs);
        ov = 0;
        cyc = (dvd == 0) ? ZERO_CYC : 16;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                               input int eq, input int er, input int eov, input int ecyc);
    int q, r, ov, cyc;
    apply_stimulus(dvd, dvs, q, r, ov, cyc);
    check_output({tag, " cycles"}, cyc, ecyc);
    check_output({tag, " quotient"}, q, eq);
    check_output({tag, " remainder"}, r, er);
    check_output({tag, " overflow"}, ov, eov);
  endtask

  initial begin
    int q, r, ov, cyc, eq, er, eov, ecyc;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int hold_q;

    vecs[0] = '{16'd1000,  8'd7,   142, 6,   0, 16};
    vecs[1] = '{16'hFEFF,  8'hFF,  255, 254, 0, 16};
    vecs[2] = '{16'h1234,  8'd0,   0,   0,   1, 0};
    vecs[3] = '{16'h0500,  8'd5,   0,   0,   1, 0};
    vecs[4] = '{16'd255,   8'd16,  15,  15,  0, 16};
    vecs[5] = '{16'd0,     8'd3,   0,   0,   0, ZERO_CYC};
    vecs[6] = '{16'h04FF,  8'd5,   255, 4,   0, 16};

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_output("reset quotient", int'(quotient), 0);
    check_output("reset remainder", int'(remainder), 0);
    check_output("reset overflow", int'(overflow), 0);
    check_output("reset Ready", int'(Ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
                    vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_ov, vecs[i].exp_cyc);
    end

    // Overflow result holds while idle.
    run_and_check("ovf", 16'hABCD, 8'd0, 0, 0, 1, 0);
    repeat (3) @(posedge clock);
    #1;
    check_output("ovf hold", int'(overflow), 1);

    // Start pulsed mid-operation is ignored.
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    dividend = 16'h0500;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
    start = 1'b0;
    while (!Ready && cyc < TIMEOUT) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("midstart cycles", cyc, 16);
    check_output("midstart quotient", int'(quotient), 142);
    check_output("midstart remainder", int'(remainder), 6);
    check_output("midstart overflow", int'(overflow), 0);

    // Result holds while start stays low.
    hold_q = int'(quotient);
    repeat (4) @(posedge clock);
    #1;
    check_output("hold quotient", int'(quotient), 142);
    check_output("hold Ready", int'(Ready), 1);
    check_output("hold stable", int'(quotient), hold_q);

    // Asynchronous reset at cycle 7 of a divide.
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    check_output("pre-reset Ready", int'(Ready), 0);
    reset_n = 1'b0;
    #1;
    check_output("async reset quotient", int'(quotient), 0);
    check_output("async reset remainder", int'(remainder), 0);
    check_output("async reset overflow", int'(overflow), 0);
    check_output("async reset Ready", int'(Ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_and_check("post-reset", 16'd255, 8'd16, 15, 15, 0, 16);

    // Back-to-back: start held high re-accepts on the first Ready edge.
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    dividend = 16'd255;
    divisor  = 8'd16;
    cyc = 0;
    while (!Ready && cyc < TIMEOUT) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("b2b first cycles", cyc, 16);
    check_output("b2b first quotient", int'(quotient), 142);
    check_output("b2b first remainder", int'(remainder), 6);
    @(posedge clock);
    #1;
    start = 1'b0;
    check_output("b2b reaccept Ready", int'(Ready), 0);
    cyc = 0;
    while (!Ready && cyc < TIMEOUT) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("b2b second cycles", cyc, 16);
    check_output("b2b second quotient", int'(quotient), 15);
    check_output("b2b second remainder", int'(remainder), 15);

    // Multiplier companion: a*b divided by a returns b with remainder 0.
    for (int i = 0; i < 10; i++) begin
      int a, b;
      a = $urandom_range(1, 255);
      b = $urandom_range(0, 255);
      dvd = 16'(a * b);
      dvs = 8'(a);
      model(dvd, dvs, eq, er, eov, ecyc);
      apply_stimulus(dvd, dvs, q, r, ov, cyc);
      check_output($sformatf("product%0d quotient", i), q, b);
      check_output($sformatf("product%0d remainder", i), r, 0);
      check_output($sformatf("product%0d cycles", i), cyc, ecyc);
    end

    // Random requests against the model; odd iterations keep the upper
    // dividend half below the divisor so most of them divide normally.
    for (int i = 0; i < 40; i++) begin
      dvs = 8'($urandom_range(0, 255));
      dvd = 16'($urandom_range(0, 65535));
      if ((i % 2) == 1 && dvs != 0)
        dvd[15:8] = 8'($urandom_range(0, int'(dvs) - 1));
      if (i % 10 == 3)
        dvd = '0;
      model(dvd, dvs, eq, er, eov, ecyc);
      run_and_check($sformatf("rand%0d", i), dvd, dvs, eq, er, eov, ecyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
